// File: rtl/vga_sync_timing_detector.sv
// Sync timing detector: measures incoming h/v sync timing and tracks
// lock on a stable line period, emitting per-line and per-frame strobes.
module vga_sync_timing_detector #(
    parameter int COUNTER_SIZE = 11,
    parameter int LOCK_LINES   = 4
) (
    input  logic                    control_clock,
    input  logic                    reset,
    input  logic                    h_sync,
    input  logic                    v_sync,
    output logic                    locked,
    output logic [COUNTER_SIZE-1:0] h_period,
    output logic [COUNTER_SIZE-1:0] h_pulse,
    output logic [COUNTER_SIZE-1:0] v_lines,
    output logic [COUNTER_SIZE-1:0] h_position,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    unlock_event
);

    localparam logic [COUNTER_SIZE-1:0] CNT_MAX    = '1;
    localparam logic [3:0]              MATCH_DONE = 4'(LOCK_LINES - 1);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t state, state_nx;

    logic [1:0] h_meta, v_meta;
    logic       h_dly, v_dly;
    logic       h_rise, h_fall, v_rise;

    logic [COUNTER_SIZE-1:0] h_cnt, h_cnt_inc;
    logic [COUNTER_SIZE-1:0] line_cnt, line_inc;
    logic [COUNTER_SIZE-1:0] pulse_cand;
    logic [COUNTER_SIZE-1:0] last_period, last_nx;
    logic [COUNTER_SIZE-1:0] period_nx, pulse_nx;
    logic [3:0]              match_cnt, match_nx;
    logic                    last_ok, last_ok_nx;
    logic                    period_ok, timeout;
    logic                    line_nx, frame_nx, unlock_nx;

    // Two synchronizer flops, then a registered edge detect.
    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            h_meta <= '0;
            v_meta <= '0;
            h_dly  <= 1'b0;
            v_dly  <= 1'b0;
            h_rise <= 1'b0;
            h_fall <= 1'b0;
            v_rise <= 1'b0;
        end else begin
            h_meta <= {h_meta[0], h_sync};
            v_meta <= {v_meta[0], v_sync};
            h_dly  <= h_meta[1];
            v_dly  <= v_meta[1];
            h_rise <= h_meta[1] & ~h_dly;
            h_fall <= ~h_meta[1] & h_dly;
            v_rise <= v_meta[1] & ~v_dly;
        end
    end

    assign h_cnt_inc  = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 1'b1;
    assign line_inc   = (line_cnt == CNT_MAX) ? CNT_MAX : line_cnt + 1'b1;
    assign period_ok  = (h_cnt != CNT_MAX);
    // Fires on the edge where h_cnt lands on its saturation value.
    assign timeout    = ~h_rise & (h_cnt_inc == CNT_MAX);
    assign h_position = h_cnt;
    assign locked     = (state == LOCKED);

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            h_cnt      <= '0;
            line_cnt   <= '0;
            v_lines    <= '0;
            pulse_cand <= '0;
        end else begin
            h_cnt <= h_rise ? '0 : h_cnt_inc;
            if (h_fall) begin
                pulse_cand <= h_cnt_inc;
            end
            if (v_rise) begin
                v_lines  <= line_cnt;
                line_cnt <= h_rise ? COUNTER_SIZE'(1) : '0;
            end else if (h_rise) begin
                line_cnt <= line_inc;
            end
        end
    end

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            state        <= SEARCH;
            match_cnt    <= '0;
            last_period  <= '0;
            last_ok      <= 1'b0;
            h_period     <= '0;
            h_pulse      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            unlock_event <= 1'b0;
        end else begin
            state        <= state_nx;
            match_cnt    <= match_nx;
            last_period  <= last_nx;
            last_ok      <= last_ok_nx;
            h_period     <= period_nx;
            h_pulse      <= pulse_nx;
            line_start   <= line_nx;
            frame_start  <= frame_nx;
            unlock_event <= unlock_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        match_nx   = match_cnt;
        last_nx    = last_period;
        last_ok_nx = last_ok;
        period_nx  = h_period;
        pulse_nx   = h_pulse;
        unlock_nx  = 1'b0;
        line_nx    = h_rise & (state == LOCKED);
        frame_nx   = v_rise & (state == LOCKED);
        unique case (state)
            SEARCH: begin
                if (h_rise) begin
                    state_nx   = MEASURE;
                    match_nx   = '0;
                    last_ok_nx = 1'b0;
                end
            end
            MEASURE: begin
                if (h_rise) begin
                    if (period_ok) begin
                        if (last_ok && (h_cnt_inc == last_period)) begin
                            match_nx = match_cnt + 4'd1;
                            if (match_nx >= MATCH_DONE) begin
                                state_nx  = LOCKED;
                                period_nx = h_cnt_inc;
                                pulse_nx  = pulse_cand;
                            end
                        end else begin
                            match_nx = '0;
                        end
                        last_nx    = h_cnt_inc;
                        last_ok_nx = 1'b1;
                    end else begin
                        match_nx   = '0;
                        last_ok_nx = 1'b0;
                    end
                end else if (timeout) begin
                    state_nx = SEARCH;
                end
            end
            LOCKED: begin
                if (h_rise) begin
                    if (period_ok && (h_cnt_inc == h_period)) begin
                        pulse_nx = pulse_cand;
                    end else begin
                        state_nx  = SEARCH;
                        unlock_nx = 1'b1;
                        line_nx   = 1'b0;
                    end
                end else if (timeout) begin
                    state_nx  = SEARCH;
                    unlock_nx = 1'b1;
                end
            end
            default: begin
                state_nx = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_sync_timing_detector.sv
// Directed bench for vga_sync_timing_detector with a strobe/lock
// scoreboard keyed on the cycle each driven edge should surface.
module tb_vga_sync_timing_detector;

    logic        clk, rst;
    logic        h_sync, v_sync, h2, v2;
    logic        locked, line_start, frame_start, unlock_event;
    logic [10:0] h_period, h_pulse, v_lines, h_position;
    logic        locked2, line_start2, frame_start2, unlock_event2;
    logic [10:0] h_period2, h_pulse2, v_lines2, h_position2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rise = 0;

    typedef struct {
        int due;
        bit ls;
        bit fs;
        bit ue;
        bit ck;
        bit lk;
    } ev_t;
    ev_t ev_q[$];

    vga_sync_timing_detector #(.COUNTER_SIZE(11), .LOCK_LINES(4)) dut (
        .control_clock(clk), .reset(rst),
        .h_sync(h_sync), .v_sync(v_sync),
        .locked(locked), .h_period(h_period), .h_pulse(h_pulse),
        .v_lines(v_lines), .h_position(h_position),
        .line_start(line_start), .frame_start(frame_start),
        .unlock_event(unlock_event)
    );

    vga_sync_timing_detector #(.COUNTER_SIZE(11), .LOCK_LINES(2)) dut2 (
        .control_clock(clk), .reset(rst),
        .h_sync(h2), .v_sync(v2),
        .locked(locked2), .h_period(h_period2), .h_pulse(h_pulse2),
        .v_lines(v_lines2), .h_position(h_position2),
        .line_start(line_start2), .frame_start(frame_start2),
        .unlock_event(unlock_event2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit els, efs, eue, eck, elk;
        ev_t e;
        els = 0; efs = 0; eue = 0; eck = 0; elk = 0;
        @(negedge clk);
        cyc++;
        while (ev_q.size() > 0 && ev_q[0].due <= cyc) begin
            e = ev_q.pop_front();
            els |= e.ls;
            efs |= e.fs;
            eue |= e.ue;
            if (e.ck) begin
                eck = 1;
                elk = e.lk;
            end
        end
        if (line_start || els)
            check("line_start", 32'(line_start), 32'(els));
        if (frame_start || efs)
            check("frame_start", 32'(frame_start), 32'(efs));
        if (unlock_event || eue)
            check("unlock_event", 32'(unlock_event), 32'(eue));
        if (eck)
            check("locked_at_due", 32'(locked), 32'(elk));
    endtask

    task automatic send_line(int period, int width, bit vr,
                             bit ls, bit fs, bit ue, bit lk);
        ev_t e;
        h_sync = 1'b1;
        v_sync = vr;
        last_rise = cyc;
        e = '{cyc + 4, ls, fs, ue, 1'b1, lk};
        ev_q.push_back(e);
        for (int i = 1; i < period; i++) begin
            tick();
            if (i == width) h_sync = 1'b0;
            if (i == 3) v_sync = 1'b0;
        end
        tick();
    endtask

    task automatic chk_zero();
        check("rst_locked", 32'(locked), 0);
        check("rst_h_period", 32'(h_period), 0);
        check("rst_h_pulse", 32'(h_pulse), 0);
        check("rst_v_lines", 32'(v_lines), 0);
        check("rst_h_position", 32'(h_position), 0);
        check("rst_line_start", 32'(line_start), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_unlock_event", 32'(unlock_event), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        h_sync = 1'b0;
        v_sync = 1'b0;
        tick();
        tick();
        chk_zero();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        ev_t e;
        rst = 1'b1;
        h_sync = 1'b0; v_sync = 1'b0;
        h2 = 1'b0; v2 = 1'b0;
        do_reset();

        // Nominal: lock on the 5th rise, strobes from the 6th.
        for (int i = 1; i <= 8; i++)
            send_line(1328, 1072, 0, i >= 6, 0, 0, i >= 5);
        check("nom_h_period", 32'(h_period), 1328);
        check("nom_h_pulse", 32'(h_pulse), 1072);
        check("nom_h_position", 32'(h_position), 1324);

        // Jitter: one long line, unlock at the following rise, relock.
        send_line(1329, 1072, 0, 1, 0, 0, 1);
        send_line(1328, 1072, 0, 0, 0, 1, 0);
        for (int i = 11; i <= 14; i++)
            send_line(1328, 1072, 0, 0, 0, 0, 0);
        send_line(1328, 1072, 0, 0, 0, 0, 1);
        send_line(1328, 1072, 0, 1, 0, 0, 1);
        check("relock_h_period", 32'(h_period), 1328);

        // Timeout: no further rise, unlock as h_cnt reaches 2047.
        e = '{last_rise + 2051, 0, 0, 1, 1, 0};
        ev_q.push_back(e);
        for (int i = cyc; i < last_rise + 2050; i++) tick();
        check("to_pos_before", 32'(h_position), 2046);
        check("to_locked_before", 32'(locked), 1);
        tick();
        check("to_pos_at", 32'(h_position), 2047);
        for (int i = 0; i < 5; i++) tick();
        check("to_pos_hold", 32'(h_position), 2047);
        check("to_locked_after", 32'(locked), 0);

        // Reacquire, then async reset mid-line while locked.
        for (int i = 1; i <= 5; i++)
            send_line(1328, 1072, 0, 0, 0, 0, i == 5);
        h_sync = 1'b1;
        e = '{cyc + 4, 1, 0, 0, 1, 1};
        ev_q.push_back(e);
        for (int i = 0; i < 600; i++) tick();
        check("pre_rst_locked", 32'(locked), 1);
        #2 rst = 1'b1;
        #1 chk_zero();
        h_sync = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        for (int i = 1; i <= 6; i++)
            send_line(1328, 1072, 0, i >= 6, 0, 0, i >= 5);
        check("post_rst_h_period", 32'(h_period), 1328);
        check("post_rst_h_pulse", 32'(h_pulse), 1072);

        // Frames with short lines; simultaneous v/h rises.
        do_reset();
        for (int i = 1; i <= 10; i++)
            send_line(12, 4, 0, i >= 6, 0, 0, i >= 5);
        send_line(12, 4, 1, 1, 1, 0, 1);
        check("v_lines_first", 32'(v_lines), 10);
        for (int i = 0; i < 805; i++)
            send_line(12, 4, 0, 1, 0, 0, 1);
        check("v_lines_hold", 32'(v_lines), 10);
        send_line(12, 4, 1, 1, 1, 0, 1);
        check("v_lines_frame", 32'(v_lines), 806);
        check("short_h_period", 32'(h_period), 12);
        check("short_h_pulse", 32'(h_pulse), 4);
        check("short_h_position", 32'(h_position), 8);
        e = '{last_rise + 2051, 0, 0, 1, 1, 0};
        ev_q.push_back(e);

        // LOCK_LINES=2 instance: lock on the 3rd rise at period 800.
        for (int k = 1; k <= 4; k++) begin
            h2 = 1'b1;
            for (int i = 1; i < 800; i++) begin
                tick();
                if (i == 200) h2 = 1'b0;
                if (k == 2 && i == 4)
                    check("ll2_early", 32'(locked2), 0);
                if (k == 3 && i == 3)
                    check("ll2_pre", 32'(locked2), 0);
                if (k == 3 && i == 4) begin
                    check("ll2_locked", 32'(locked2), 1);
                    check("ll2_h_period", 32'(h_period2), 800);
                    check("ll2_h_pulse", 32'(h_pulse2), 200);
                    check("ll2_no_ls", 32'(line_start2), 0);
                end
                if (k == 4 && i == 4)
                    check("ll2_ls", 32'(line_start2), 1);
            end
            tick();
        end

        check("queue_empty", 32'(ev_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
